// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control unit: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory wait watchdog with sticky fault, and retired-instruction counter.
module multicycle_controller #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        bne_beq,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        zero_extend,
    output logic [2:0]  state,
    output logic        halted,
    output logic        mem_err,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam int unsigned WW = $clog2(MEM_WAIT_MAX + 1);

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q;
    logic          wait_limit;
    logic          fault;
    logic          is_r, is_lw, is_sw, is_br, is_imm, is_j, is_jal, is_syscall, op_known;

    // The zero flag is consumed by the datapath, gated by pc_write_cond/bne_beq.
    logic unused_zero;
    assign unused_zero = zero;

    assign is_r       = (op == 6'h00);
    assign is_lw      = (op == 6'h23);
    assign is_sw      = (op == 6'h2B);
    assign is_br      = (op == 6'h04) || (op == 6'h05);
    assign is_imm     = (op[5:3] == 3'b001);
    assign is_j       = (op == 6'h02);
    assign is_jal     = (op == 6'h03);
    assign is_syscall = is_r && (funct == 6'h0C);
    assign op_known   = is_r || is_lw || is_sw || is_br || is_imm || is_j || is_jal;

    // This cycle would be the MEM_WAIT_MAX-th unanswered request cycle.
    assign wait_limit = (wait_q == WW'(MEM_WAIT_MAX - 1));

    assign state = state_q;

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        bne_beq       = 1'b0;
        pc_src        = 2'd0;
        reg_write     = 1'b0;
        reg_dst       = 2'd0;
        mem_to_reg    = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        zero_extend   = 1'b0;
        halted        = 1'b0;
        fault         = 1'b0;
        state_d       = state_q;

        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else if (wait_limit) begin
                    fault   = 1'b1;
                    state_d = HALT;
                end
            end
            DECODE: begin
                alu_src_b = 2'd3;
                if (is_j || is_jal) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                    state_d  = FETCH;
                    if (is_jal) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                    end
                end else if (is_syscall || !op_known) begin
                    state_d = HALT;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_src_a = 1'b1;
                if (is_r) begin
                    alu_op  = 2'd2;
                    state_d = WB;
                end else if (is_lw || is_sw) begin
                    alu_src_b = 2'd2;
                    state_d   = MEM;
                end else if (is_br) begin
                    alu_op        = 2'd1;
                    pc_write_cond = 1'b1;
                    pc_src        = 2'd1;
                    bne_beq       = (op == 6'h05);
                    state_d       = FETCH;
                end else if (is_imm) begin
                    alu_src_b   = 2'd2;
                    alu_op      = 2'd3;
                    zero_extend = (op[2:0] >= 3'd4);
                    state_d     = WB;
                end else begin
                    state_d = HALT;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = is_sw;
                if (mem_ready) begin
                    state_d = is_lw ? WB : FETCH;
                end else if (wait_limit) begin
                    fault   = 1'b1;
                    state_d = HALT;
                end
            end
            WB: begin
                reg_write  = 1'b1;
                reg_dst    = is_r ? 2'd1 : 2'd0;
                mem_to_reg = is_lw ? 2'd1 : 2'd0;
                state_d    = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            wait_q      <= '0;
            mem_err     <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || mem_ready || !mem_req) begin
                wait_q <= '0;
            end else begin
                wait_q <= wait_q + 1'b1;
            end
            if (fault) begin
                mem_err <= 1'b1;
            end
            if (state_d == FETCH && state_q inside {DECODE, EXEC, MEM, WB}) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: a per-instruction reference model queues expected cycle
// records; a negedge monitor pops and compares them against the controller.
module tb_multicycle_controller;

    localparam int unsigned MAXW = 6;

    localparam int C_R    = 0;
    localparam int C_LW   = 1;
    localparam int C_SW   = 2;
    localparam int C_BR   = 3;
    localparam int C_I    = 4;
    localparam int C_J    = 5;
    localparam int C_JAL  = 6;
    localparam int C_HALT = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  op = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, bne_beq;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic [1:0]  reg_dst, mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b, alu_op;
    logic        zero_extend;
    logic [2:0]  state;
    logic        halted, mem_err;
    logic [31:0] instr_count;

    multicycle_controller #(.MEM_WAIT_MAX(MAXW)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .bne_beq(bne_beq), .pc_src(pc_src), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .zero_extend(zero_extend),
        .state(state), .halted(halted), .mem_err(mem_err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, bne_beq;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b, alu_op;
        logic       zero_extend;
    } ctrl_t;

    typedef struct packed {
        logic [2:0]  st;
        ctrl_t       c;
        logic        halted;
        logic        err;
        logic [31:0] cnt;
    } rec_t;

    rec_t        sb[$];
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] exp_cnt = '0;
    logic        exp_err = 1'b0;

    function automatic int cls(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) return (f == 6'h0C) ? C_HALT : C_R;
        if (o == 6'h23) return C_LW;
        if (o == 6'h2B) return C_SW;
        if (o == 6'h04 || o == 6'h05) return C_BR;
        if (o >= 6'h08 && o <= 6'h0F) return C_I;
        if (o == 6'h02) return C_J;
        if (o == 6'h03) return C_JAL;
        return C_HALT;
    endfunction

    function automatic ctrl_t fetch_c(input logic done);
        ctrl_t c = '0;
        c.mem_req   = 1'b1;
        c.alu_src_b = 2'd1;
        c.ir_write  = done;
        c.pc_write  = done;
        return c;
    endfunction

    function automatic ctrl_t decode_c(input logic [5:0] o);
        ctrl_t c = '0;
        c.alu_src_b = 2'd3;
        if (o == 6'h02 || o == 6'h03) begin
            c.pc_write = 1'b1;
            c.pc_src   = 2'd2;
        end
        if (o == 6'h03) begin
            c.reg_write  = 1'b1;
            c.reg_dst    = 2'd2;
            c.mem_to_reg = 2'd2;
        end
        return c;
    endfunction

    function automatic ctrl_t exec_c(input logic [5:0] o, input logic [5:0] f);
        ctrl_t c = '0;
        c.alu_src_a = 1'b1;
        case (cls(o, f))
            C_R: c.alu_op = 2'd2;
            C_LW, C_SW: c.alu_src_b = 2'd2;
            C_BR: begin
                c.alu_op        = 2'd1;
                c.pc_write_cond = 1'b1;
                c.pc_src        = 2'd1;
                c.bne_beq       = (o == 6'h05);
            end
            C_I: begin
                c.alu_src_b   = 2'd2;
                c.alu_op      = 2'd3;
                c.zero_extend = (o >= 6'h0C);
            end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctrl_t mem_c(input logic [5:0] o);
        ctrl_t c = '0;
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
        c.mem_we  = (o == 6'h2B);
        return c;
    endfunction

    function automatic ctrl_t wb_c(input logic [5:0] o, input logic [5:0] f);
        ctrl_t c = '0;
        c.reg_write = 1'b1;
        if (cls(o, f) == C_R) c.reg_dst = 2'd1;
        if (cls(o, f) == C_LW) c.mem_to_reg = 2'd1;
        return c;
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            rec_t e, a;
            e = sb.pop_front();
            a.st = state;
            a.c = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, bne_beq,
                   pc_src, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                   alu_op, zero_extend};
            a.halted = halted;
            a.err = mem_err;
            a.cnt = instr_count;
            compared++;
            if (a !== e) begin
                mismatched++;
                $display("FAIL cycle @%0t op=%h: got st=%0d ctrl=%h halted=%b err=%b cnt=%0d, want st=%0d ctrl=%h halted=%b err=%b cnt=%0d",
                         $time, op, a.st, a.c, a.halted, a.err, a.cnt,
                         e.st, e.c, e.halted, e.err, e.cnt);
            end
        end
    end

    // Drive one cycle's inputs just after a rising edge and queue its expectation.
    task automatic cyc(input logic [2:0] st, input ctrl_t c, input logic r);
        rec_t e;
        e.st     = st;
        e.c      = c;
        e.halted = (st == 3'd5);
        e.err    = exp_err;
        e.cnt    = exp_cnt;
        mem_ready = r;
        zero      = 1'($urandom_range(0, 1));
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic mem_phase(input logic [2:0] st, input ctrl_t base, input ctrl_t done,
                             input int w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= int'(MAXW); i++) begin
            if (i == w) begin
                cyc(st, done, 1'b1);
                ok = 1'b1;
                return;
            end
            cyc(st, base, 1'b0);
            if (i == int'(MAXW) - 1) begin
                exp_err = 1'b1;
                return;
            end
        end
    endtask

    task automatic halt_tail();
        repeat (3) begin
            op = 6'($urandom);
            cyc(3'd5, '0, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        compared++;
        if ({state, instr_count, mem_err, halted, mem_req} !== {3'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL async_reset: got st=%0d cnt=%0d err=%b halted=%b mem_req=%b, want st=0 cnt=0 err=0 halted=0 mem_req=1",
                     state, instr_count, mem_err, halted, mem_req);
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_cnt = '0;
        exp_err = 1'b0;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fw,
                             input int mw, output bit stopped);
        bit ok;
        int k;
        stopped = 1'b0;
        op    = o;
        funct = f;
        k     = cls(o, f);
        mem_phase(3'd0, fetch_c(1'b0), fetch_c(1'b1), fw, ok);
        if (!ok) begin
            halt_tail();
            stopped = 1'b1;
            return;
        end
        cyc(3'd1, decode_c(o), 1'($urandom_range(0, 1)));
        if (k == C_J || k == C_JAL) begin
            exp_cnt++;
            return;
        end
        if (k == C_HALT) begin
            halt_tail();
            stopped = 1'b1;
            return;
        end
        cyc(3'd2, exec_c(o, f), 1'($urandom_range(0, 1)));
        if (k == C_BR) begin
            exp_cnt++;
            return;
        end
        if (k == C_LW || k == C_SW) begin
            mem_phase(3'd3, mem_c(o), mem_c(o), mw, ok);
            if (!ok) begin
                halt_tail();
                stopped = 1'b1;
                return;
            end
            if (k == C_SW) begin
                exp_cnt++;
                return;
            end
        end
        cyc(3'd4, wb_c(o, f), 1'($urandom_range(0, 1)));
        exp_cnt++;
    endtask

    function automatic int pick_wait();
        int x = $urandom_range(0, 99);
        if (x < 3) return int'(MAXW);
        if (x < 10) return int'(MAXW) - 1;
        return $urandom_range(0, 2);
    endfunction

    initial begin
        bit st;
        logic [5:0] o, f;
        int r;

        @(posedge clk);
        #1;
        do_reset();

        run_instr(6'h00, 6'h20, 0, 0, st);
        run_instr(6'h23, 6'h00, 1, 2, st);
        run_instr(6'h2B, 6'h00, 0, 0, st);
        run_instr(6'h04, 6'h00, 0, 0, st);
        run_instr(6'h05, 6'h00, 0, 0, st);
        run_instr(6'h03, 6'h00, 0, 0, st);
        run_instr(6'h0D, 6'h00, 0, 0, st);
        run_instr(6'h00, 6'h22, int'(MAXW) - 1, 0, st);
        run_instr(6'h23, 6'h00, 0, int'(MAXW) - 1, st);

        // Interrupt a load mid-MEM with an asynchronous reset.
        op = 6'h23;
        cyc(3'd0, fetch_c(1'b1), 1'b1);
        cyc(3'd1, decode_c(6'h23), 1'b0);
        cyc(3'd2, exec_c(6'h23, 6'h00), 1'b0);
        cyc(3'd3, mem_c(6'h23), 1'b0);
        do_reset();

        run_instr(6'h00, 6'h20, int'(MAXW), 0, st);
        do_reset();
        run_instr(6'h00, 6'h0C, 0, 0, st);
        do_reset();
        run_instr(6'h3F, 6'h00, 0, 0, st);
        do_reset();
        run_instr(6'h2B, 6'h00, 0, int'(MAXW), st);
        do_reset();

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            f = 6'($urandom);
            if (r < 20)      o = 6'h00;
            else if (r < 35) o = 6'h23;
            else if (r < 45) o = 6'h2B;
            else if (r < 55) o = 6'($urandom_range(4, 5));
            else if (r < 75) o = 6'($urandom_range(8, 15));
            else if (r < 82) o = 6'h02;
            else if (r < 88) o = 6'h03;
            else             o = 6'($urandom);
            run_instr(o, f, pick_wait(), pick_wait(), st);
            if (st) do_reset();
        end

        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
